wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback stage (the selected writeback result);
  - a long-latency execution unit, such as a multi-cycle divider.
- Long-latency results are queued in a small FIFO. The pipeline normally has priority.
- A starvation counter forces the queued results through by stalling the pipeline.
- Stale queued results are squashed by younger pipeline writes to the same rd.

---
 rtl/wb_port_arbiter.sv | 131 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs queued long-latency results (optional WB_ARB_BYPASS_EN).
// Latency: rf_* registered one cycle after grant; queued lu results need >=2 cycles unless bypassed.
// Backpressure: lu_ready_o drops while the FIFO is full; stall_o holds the pipeline when a starved FIFO head is forced through.
module wb_port_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pipe_valid_i,
    input  logic [4:0]              pipe_rd_i,
    input  logic [31:0]             pipe_data_i,
    output logic                    stall_o,
    input  logic                    lu_valid_i,
    output logic                    lu_ready_o,
    input  logic [4:0]              lu_rd_i,
    input  logic [31:0]             lu_data_i,
    output logic                    rf_we_o,
    output logic [4:0]              rf_rd_o,
    output logic [31:0]             rf_wd_o,
    output logic [$clog2(DEPTH):0]  buf_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [4:0]       fifo_rd_q   [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [DEPTH-1:0] kill_q, kill_d;
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_rd_q, rf_rd_d;
    logic [31:0]      rf_wd_q, rf_wd_d;

    logic head_vld, head_kill, head_live;
    logic lu_grant, pipe_grant, bypass, push, pop, squash;

    assign head_vld   = (count_q != '0);
    assign head_kill  = kill_q[rptr_q];
    assign head_live  = head_vld && !head_kill;
    assign lu_grant   = head_live && (!pipe_valid_i || wait_q == WW'(MAX_WAIT));
    assign pipe_grant = pipe_valid_i && !lu_grant;
    assign stall_o    = pipe_valid_i && lu_grant;
    assign lu_ready_o = (count_q < CW'(DEPTH));

`ifdef WB_ARB_BYPASS_EN
    // Idle port and empty queue: the result skips the FIFO and writes next cycle.
    assign bypass = lu_valid_i && !head_vld && !pipe_valid_i;
`else
    assign bypass = 1'b0;
`endif

    assign push   = lu_valid_i && lu_ready_o && !bypass;
    assign pop    = head_vld && (head_kill || lu_grant);
    assign squash = pipe_grant && (pipe_rd_i != 5'd0);

    always_comb begin
        kill_d = kill_q;
        if (squash) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fifo_rd_q[i] == pipe_rd_i) kill_d[i] = 1'b1;
            end
        end
        // A result pushed alongside a younger pipe write to the same rd is born dead.
        if (push) kill_d[wptr_q] = squash && (lu_rd_i == pipe_rd_i);
    end

    always_comb begin
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
        wait_d  = wait_q;
        if (!head_live || lu_grant) begin
            wait_d = '0;
        end else if (wait_q != WW'(MAX_WAIT)) begin
            wait_d = wait_q + WW'(1);
        end
    end

    always_comb begin
        rf_rd_d = rf_rd_q;
        rf_wd_d = rf_wd_q;
        if (lu_grant) begin
            rf_rd_d = fifo_rd_q[rptr_q];
            rf_wd_d = fifo_data_q[rptr_q];
        end else if (bypass) begin
            rf_rd_d = lu_rd_i;
            rf_wd_d = lu_data_i;
        end else if (pipe_grant) begin
            rf_rd_d = pipe_rd_i;
            rf_wd_d = pipe_data_i;
        end
        rf_we_d = (lu_grant || bypass || pipe_grant) && (rf_rd_d != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wptr_q]   <= lu_rd_i;
            fifo_data_q[wptr_q] <= lu_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kill_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            wait_q  <= '0;
            rf_we_q <= 1'b0;
            rf_rd_q <= '0;
            rf_wd_q <= '0;
        end else begin
            kill_q  <= kill_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            rf_we_q <= rf_we_d;
            rf_rd_q <= rf_rd_d;
            rf_wd_q <= rf_wd_d;
        end
    end

    assign rf_we_o     = rf_we_q;
    assign rf_rd_o     = rf_rd_q;
    assign rf_wd_o     = rf_wd_q;
    assign buf_count_o = count_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed stimulus, expected writes queued in issue order, monitor checks rf port.
// Latency: n/a. Backpressure: n/a.
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid_i;
    logic [4:0]  pipe_rd_i;
    logic [31:0] pipe_data_i;
    logic        stall_o;
    logic        lu_valid_i;
    logic        lu_ready_o;
    logic [4:0]  lu_rd_i;
    logic [31:0] lu_data_i;
    logic        rf_we_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_wd_o;
    logic [2:0]  buf_count_o;

    int n_chk  = 0;
    int n_fail = 0;
    logic [36:0] exp_q[$];

    wb_port_arbiter #(.DEPTH(4), .MAX_WAIT(3)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid_i(pipe_valid_i), .pipe_rd_i(pipe_rd_i), .pipe_data_i(pipe_data_i),
        .stall_o(stall_o),
        .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o), .lu_rd_i(lu_rd_i), .lu_data_i(lu_data_i),
        .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_wd_o(rf_wd_o),
        .buf_count_o(buf_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic expw(input logic [4:0] rd, input logic [31:0] wd);
        exp_q.push_back({rd, wd});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
        pipe_valid_i = v;
        pipe_rd_i    = rd;
        pipe_data_i  = d;
    endtask

    task automatic drive_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lu_valid_i = v;
        lu_rd_i    = rd;
        lu_data_i  = d;
    endtask

    // Monitor: every rf write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rf_we_o === 1'b1) begin
            logic [36:0] e;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got write x%0d=0x%0h, required no write", rf_rd_o, rf_wd_o);
            end else begin
                e = exp_q.pop_front();
                if ({rf_rd_o, rf_wd_o} !== e) begin
                    n_fail++;
                    $display("FAIL sb_write: got x%0d=0x%0h, required x%0d=0x%0h",
                             rf_rd_o, rf_wd_o, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with a pipe request asserted
        rst = 1'b1;
        drive_lu(0, 0, 0);
        drive_pipe(1, 5, 32'h99);
        step; step;
        chk("rst_we",  32'(rf_we_o), 0);
        chk("rst_cnt", 32'(buf_count_o), 0);
        chk("rst_rdy", 32'(lu_ready_o), 1);
        rst = 1'b0;
        drive_pipe(1, 5, 32'h11);
        expw(5, 32'h11);
        step;
        chk("t1_we", 32'(rf_we_o), 1);
        chk("t1_rd", 32'(rf_rd_o), 5);
        chk("t1_wd", rf_wd_o, 32'h11);
        drive_pipe(0, 0, 0);
        step;
        chk("t1_idle_we", 32'(rf_we_o), 0);

        // Starvation: pipe wins three cycles, then the aged head is forced
        drive_pipe(1, 1, 32'h10);
        drive_lu(1, 7, 32'hAA);
        expw(1, 32'h10);
        step;
        drive_lu(0, 0, 0);
        for (int i = 2; i <= 4; i++) begin
            drive_pipe(1, 5'(i), 32'(16 * i));
            #1 chk("t2_no_stall", 32'(stall_o), 0);
            expw(5'(i), 32'(16 * i));
            step;
        end
        drive_pipe(1, 6, 32'h60);
        #1 chk("t2_stall", 32'(stall_o), 1);
        expw(7, 32'hAA);
        step;
        chk("t2_lu_rd", 32'(rf_rd_o), 7);
        chk("t2_lu_wd", rf_wd_o, 32'hAA);
        chk("t2_held_stall", 32'(stall_o), 0);
        expw(6, 32'h60);
        step;
        chk("t2_held_rd", 32'(rf_rd_o), 6);
        drive_pipe(0, 0, 0);
        step;

        // Squash: queued x9 and a same-cycle x9 push are killed by pipe x9
        drive_pipe(1, 8, 32'h80);
        drive_lu(1, 9, 32'h1);
        expw(8, 32'h80);
        step;
        drive_pipe(1, 9, 32'h2);
        drive_lu(1, 9, 32'h3);
        #1 chk("t3_stall", 32'(stall_o), 0);
        expw(9, 32'h2);
        step;
        chk("t3_cnt2", 32'(buf_count_o), 2);
        drive_pipe(0, 0, 0);
        drive_lu(0, 0, 0);
        step;
        chk("t3_kill1_we", 32'(rf_we_o), 0);
        chk("t3_kill1_cnt", 32'(buf_count_o), 1);
        step;
        chk("t3_kill2_we", 32'(rf_we_o), 0);
        chk("t3_kill2_cnt", 32'(buf_count_o), 0);

        // Fill to DEPTH while the pipe keeps winning
        for (int i = 0; i < 4; i++) begin
            drive_pipe(1, 5'(i + 1), 32'h200 + 32'(i));
            drive_lu(1, 5'(10 + i), 32'h100 + 32'(i));
            #1 chk("t4_fill_rdy", 32'(lu_ready_o), 1);
            expw(5'(i + 1), 32'h200 + 32'(i));
            step;
        end
        drive_pipe(0, 0, 0);
        drive_lu(0, 0, 0);
        #1 chk("t4_full_rdy", 32'(lu_ready_o), 0);
        chk("t4_full_cnt", 32'(buf_count_o), 4);
        for (int i = 0; i < 4; i++) begin
            expw(5'(10 + i), 32'h100 + 32'(i));
            step;
        end
        chk("t4_drain_cnt", 32'(buf_count_o), 0);
        chk("t4_drain_rdy", 32'(lu_ready_o), 1);

        // Pointer wrap: one entry resident, ten push/pop pairs
        drive_pipe(1, 1, 32'h300);
        drive_lu(1, 16, 32'h1000);
        expw(1, 32'h300);
        step;
        drive_pipe(0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            drive_lu(1, 5'(16 + i % 8), 32'h1000 + 32'(i));
            expw(5'(16 + (i - 1) % 8), 32'h1000 + 32'(i - 1));
            step;
            chk("t4_wrap_cnt", 32'(buf_count_o), 1);
        end
        drive_lu(0, 0, 0);
        expw(5'(16 + 10 % 8), 32'h100A);
        step;
        chk("t4_wrap_end_cnt", 32'(buf_count_o), 0);

        // x0: no writes, and a queued rd=0 entry survives pipe rd=0 (it starves, then is forced)
        drive_pipe(1, 0, 32'h55);
        drive_lu(1, 0, 32'h66);
        step;
        chk("t5_pipe_we", 32'(rf_we_o), 0);
        drive_lu(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t5_no_stall", 32'(stall_o), 0);
            step;
        end
        #1 chk("t5_stall", 32'(stall_o), 1);
        step;
        chk("t5_lu_we", 32'(rf_we_o), 0);
        chk("t5_cnt", 32'(buf_count_o), 0);
        drive_pipe(0, 0, 0);
        step;

        // Direct lu result into an idle port
        drive_lu(1, 3, 32'h33);
        #1 chk("t6_rdy", 32'(lu_ready_o), 1);
        expw(3, 32'h33);
        step;
        drive_lu(0, 0, 0);
`ifdef WB_ARB_BYPASS_EN
        chk("t6_byp_we", 32'(rf_we_o), 1);
        chk("t6_byp_cnt", 32'(buf_count_o), 0);
`else
        chk("t6_q_we", 32'(rf_we_o), 0);
        chk("t6_q_cnt", 32'(buf_count_o), 1);
        step;
        chk("t6_q_we2", 32'(rf_we_o), 1);
        chk("t6_q_rd", 32'(rf_rd_o), 3);
        chk("t6_q_cnt2", 32'(buf_count_o), 0);
`endif
        step; step;
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
